// File: rtl/cdb_broadcast_arbiter_if.sv
// Common data bus handshake bundle: per-unit producer results in,
// registered single-result broadcast out.
interface cdb_broadcast_arbiter_if #(
    parameter int ROB    = 2,
    parameter int WIDTH  = 31,
    parameter int NUM_FU = 4
);
    logic [NUM_FU-1:0]           fuValid;
    logic [NUM_FU*(ROB+1)-1:0]   fuRobEntry;
    logic [NUM_FU*(WIDTH+1)-1:0] fuResult;
    logic [NUM_FU-1:0]           fuReady;
    logic                        cdbValid;
    logic [ROB:0]                cdbRobEntry;
    logic [WIDTH:0]              cdbResult;

    modport master (
        output fuValid, fuRobEntry, fuResult,
        input  fuReady, cdbValid, cdbRobEntry, cdbResult
    );

    modport slave (
        input  fuValid, fuRobEntry, fuResult,
        output fuReady, cdbValid, cdbRobEntry, cdbResult
    );
endinterface

// File: rtl/cdb_broadcast_arbiter.sv
// CDB transmit side: per-unit 2-entry result FIFOs, round-robin
// selection and a registered one-result-per-cycle broadcast.
module cdb_broadcast_arbiter #(
    parameter int ROB    = 2,
    parameter int WIDTH  = 31,
    parameter int NUM_FU = 4
) (
    input  logic clk,
    input  logic resetN,
    input  logic flush,
    cdb_broadcast_arbiter_if.slave bus
);
    localparam int TW = ROB + 1;
    localparam int DW = WIDTH + 1;
    localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    typedef struct packed {
        logic          validBroadcast;
        logic [TW-1:0] robEntry;
        logic [DW-1:0] result;
    } cdb_t;

    cdb_t                 r_commonDataBus;
    logic [PW-1:0]        r_rrPtr;
    logic [NUM_FU-1:0]    w_ready;
    logic [NUM_FU-1:0]    w_push;
    logic [NUM_FU-1:0]    w_pop;
    logic [NUM_FU-1:0]    w_nonEmpty;
    logic [NUM_FU*TW-1:0] w_headTag;
    logic [NUM_FU*DW-1:0] w_headRes;
    logic                 w_gntAny;
    logic [PW-1:0]        w_gnt;
    logic [PW-1:0]        w_idx;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        logic [TW-1:0] r_tag0, r_tag1;
        logic [DW-1:0] r_res0, r_res1;
        logic [1:0]    r_cnt;
        logic [TW-1:0] w_inTag;
        logic [DW-1:0] w_inRes;

        assign w_inTag = bus.fuRobEntry[i*TW +: TW];
        assign w_inRes = bus.fuResult[i*DW +: DW];
        assign w_ready[i] = (r_cnt != 2'd2) & ~flush & resetN;
        assign w_push[i] = bus.fuValid[i] & w_ready[i];
        assign w_nonEmpty[i] = (r_cnt != 2'd0);
        assign w_headTag[i*TW +: TW] = r_tag0;
        assign w_headRes[i*DW +: DW] = r_res0;

        // Entry 0 is always the head; entry 1 shifts down on pop.
        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                r_cnt  <= 2'd0;
                r_tag0 <= '0;
                r_tag1 <= '0;
                r_res0 <= '0;
                r_res1 <= '0;
            end else if (flush) begin
                r_cnt <= 2'd0;
            end else begin
                case ({w_push[i], w_pop[i]})
                    2'b10: begin
                        if (r_cnt == 2'd0) begin
                            r_tag0 <= w_inTag;
                            r_res0 <= w_inRes;
                        end else begin
                            r_tag1 <= w_inTag;
                            r_res1 <= w_inRes;
                        end
                        r_cnt <= r_cnt + 2'd1;
                    end
                    2'b01: begin
                        r_tag0 <= r_tag1;
                        r_res0 <= r_res1;
                        r_cnt  <= r_cnt - 2'd1;
                    end
                    2'b11: begin
                        if (r_cnt == 2'd1) begin
                            r_tag0 <= w_inTag;
                            r_res0 <= w_inRes;
                        end else begin
                            r_tag0 <= r_tag1;
                            r_res0 <= r_res1;
                            r_tag1 <= w_inTag;
                            r_res1 <= w_inRes;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_gntAny = 1'b0;
        w_gnt    = '0;
        w_idx    = '0;
        w_pop    = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            w_idx = PW'((int'(r_rrPtr) + k) % NUM_FU);
            if (!w_gntAny && w_nonEmpty[w_idx]) begin
                w_gntAny = 1'b1;
                w_gnt    = w_idx;
            end
        end
        if (w_gntAny)
            w_pop[w_gnt] = 1'b1;
    end

    // Pointer holds across a flush even if a grant was computed.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            r_rrPtr <= '0;
        else if (!flush && w_gntAny)
            r_rrPtr <= (w_gnt == PW'(NUM_FU - 1)) ? '0
                     : w_gnt + PW'(1);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_commonDataBus <= '0;
        end else if (flush || !w_gntAny) begin
            r_commonDataBus.validBroadcast <= 1'b0;
        end else begin
            r_commonDataBus.validBroadcast <= 1'b1;
            r_commonDataBus.robEntry <=
                w_headTag[int'(w_gnt)*TW +: TW];
            r_commonDataBus.result <=
                w_headRes[int'(w_gnt)*DW +: DW];
        end
    end

    assign bus.fuReady     = w_ready;
    assign bus.cdbValid    = r_commonDataBus.validBroadcast;
    assign bus.cdbRobEntry = r_commonDataBus.robEntry;
    assign bus.cdbResult   = r_commonDataBus.result;
endmodule
